// File: rtl/uart_rx_framer.sv
// Oversampled UART receiver: synchronizes the line, frames start/data/parity/stop,
// detects breaks and hands completed frames to a valid/ready consumer.
module uart_rx_framer #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 clk_en_i,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] dataout_o,
  output logic                 dataout_valid_o,
  input  logic                 dataout_ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 break_o
);

  localparam int            CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = 1'(PARITY_MODE == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } state_t;

  logic                 rx_meta_reg;
  logic                 rx_sync_reg;
  logic                 rx;

  state_t               state_reg, state_next;
  logic [CW-1:0]        tick_reg, tick_next;
  logic [3:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_bit_reg, parity_bit_next;
  logic                 ferr_reg, ferr_next;
  logic                 stop_low_reg, stop_low_next;
  logic                 armed_reg, armed_next;

  logic                 frame_done;
  logic                 frame_break;
  logic                 frame_ferr;
  logic                 frame_perr;
  logic                 deliver;
  logic                 break_det;

  assign rx = rx_sync_reg;

  // State register; the synchronizer runs every cycle, the framer only on ticks.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      state_reg      <= IDLE;
      tick_reg       <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      parity_bit_reg <= 1'b0;
      ferr_reg       <= 1'b0;
      stop_low_reg   <= 1'b0;
      armed_reg      <= 1'b0;
    end else begin
      rx_meta_reg    <= uart_rx_i;
      rx_sync_reg    <= rx_meta_reg;
      state_reg      <= state_next;
      tick_reg       <= tick_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      parity_bit_reg <= parity_bit_next;
      ferr_reg       <= ferr_next;
      stop_low_reg   <= stop_low_next;
      armed_reg      <= armed_next;
    end
  end

  // Next-state logic. armed_reg blocks a start until the line has been seen high
  // after reset, so a reset landing mid-frame cannot resume on a low data bit.
  always_comb begin
    state_next      = state_reg;
    tick_next       = tick_reg;
    bit_next        = bit_reg;
    shift_next      = shift_reg;
    parity_bit_next = parity_bit_reg;
    ferr_next       = ferr_reg;
    stop_low_next   = stop_low_reg;
    armed_next      = armed_reg;
    if (clk_en_i) begin
      case (state_reg)
        IDLE: begin
          if (rx) begin
            armed_next = 1'b1;
          end else if (armed_reg) begin
            state_next = START;
            tick_next  = '0;
          end
        end
        START: begin
          if (tick_reg == HALF_TICK) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = rx ? IDLE : DATA;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        DATA: begin
          if (tick_reg == LAST_TICK) begin
            tick_next  = '0;
            shift_next = {rx, shift_reg[DATA_BITS-1:1]};
            if (bit_reg == LAST_DATA) begin
              bit_next      = '0;
              ferr_next     = 1'b0;
              stop_low_next = 1'b1;
              state_next    = (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_next = bit_reg + 4'd1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        PARITY: begin
          if (tick_reg == LAST_TICK) begin
            tick_next       = '0;
            parity_bit_next = rx;
            state_next      = STOP;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        STOP: begin
          if (tick_reg == LAST_TICK) begin
            tick_next     = '0;
            ferr_next     = ferr_reg | ~rx;
            stop_low_next = stop_low_reg & ~rx;
            if (bit_reg == LAST_STOP) begin
              bit_next   = '0;
              state_next = frame_break ? BREAK_WAIT : IDLE;
            end else begin
              bit_next = bit_reg + 4'd1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        BREAK_WAIT: begin
          if (rx) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Frame-completion strobes, evaluated on the tick of the last stop sample.
  always_comb begin
    frame_done  = 1'b0;
    frame_ferr  = ferr_reg | ~rx;
    frame_break = 1'b0;
    frame_perr  = 1'b0;
    if (clk_en_i && state_reg == STOP && tick_reg == LAST_TICK && bit_reg == LAST_STOP) begin
      frame_done = 1'b1;
    end
    if (frame_ferr && stop_low_reg && !rx && shift_reg == '0) begin
      frame_break = 1'b1;
    end
    if (PARITY_MODE != 0) begin
      frame_perr = ((^shift_reg) ^ parity_bit_reg) != PAR_ODD;
    end
    deliver   = frame_done & ~frame_break;
    break_det = frame_done & frame_break;
  end

  // Output holding register with valid/ready handshake and overrun reporting.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      dataout_o       <= '0;
      dataout_valid_o <= 1'b0;
      parity_err_o    <= 1'b0;
      frame_err_o     <= 1'b0;
      overrun_o       <= 1'b0;
      break_o         <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      break_o   <= break_det;
      if (deliver) begin
        if (!dataout_valid_o || dataout_ready_i) begin
          dataout_o       <= shift_reg;
          parity_err_o    <= frame_perr;
          frame_err_o     <= frame_ferr;
          dataout_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (dataout_valid_o && dataout_ready_i) begin
        dataout_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
- REQ-001 Parameter DATA_BITS, default 8: payload bits per frame; legal range 5..9.
- REQ-002 Parameter PARITY_MODE, default 0: 0 = none, 1 = even, 2 = odd.
- REQ-003 Parameter STOP_BITS, default 1: legal values 1 or 2.
- REQ-004 Parameter OVERSAMPLE, default 16: clk_en_i ticks per bit; even, 4..32.
- REQ-005 clk_i  in  1: single clock; all logic on posedge clk_i.
- REQ-006 resetn_i  in  1: reset, synchronous, active-low.
- REQ-007 clk_en_i  in  1: one-cycle tick in clk_i domain at OVERSAMPLE x baud.
- REQ-008 uart_rx_i  in  1: asynchronous serial line; idle high.
- REQ-009 dataout_o  out  DATA_BITS: received payload, LSB = first bit on line.
- REQ-010 dataout_valid_o  out  1: dataout_o and error flags hold a frame.
- REQ-011 dataout_ready_i  in  1: consumer accepts the frame when high with valid.
- REQ-012 parity_err_o  out  1: parity mismatch for the held frame; always 0 when PARITY_MODE = 0.
- REQ-013 frame_err_o  out  1: a stop bit sampled low for the held frame.
- REQ-014 overrun_o  out  1: one-cycle pulse; a completed frame was dropped.
- REQ-015 break_o  out  1: one-cycle pulse; line break detected.

Function
- REQ-016 uart_rx_i shall pass a 2-flop synchronizer clocked every clk_i cycle; all sampling shall use the synchronized value.
- REQ-017 The FSM and tick counter shall advance only on cycles with clk_en_i = 1 and hold otherwise.
- REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- REQ-019 IDLE: on a tick with rx = 0, go to START with tick counter = 0.
- REQ-020 START: sample at tick count OVERSAMPLE/2-1; rx = 1 there is a glitch, so return to IDLE with no output; rx = 0 goes to DATA.
- REQ-021 DATA: sample each bit OVERSAMPLE ticks after the previous sample; shift LSB-first; after DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else STOP.
- REQ-022 PARITY: one sample; error = (XOR of data and parity bit) != (PARITY_MODE == 2).
- REQ-023 STOP: take STOP_BITS samples at OVERSAMPLE spacing; any low sample sets the frame error.
- REQ-024 Break: the frame error is set, all data bits are 0, and every stop sample is 0. Then pulse break_o, deliver no frame, and enter BREAK_WAIT.
- REQ-025 BREAK_WAIT: return to IDLE on the first tick with rx = 1.
- REQ-026 Otherwise the frame shall be delivered the clk_i cycle after the tick of the last stop sample. Delivery returns the FSM to IDLE on that same tick, so back-to-back frames are accepted.
- REQ-027 Delivery when dataout_valid_o = 0: load dataout_o, parity_err_o and frame_err_o, and set valid, all in the same cycle.
- REQ-028 Handshake: valid & ready clears valid the next cycle; dataout_o and the error flags hold until replaced.
- REQ-029 Delivery in the same cycle as valid & ready: load the new frame and keep valid = 1; no overrun.
- REQ-030 Delivery while valid = 1 and ready = 0: pulse overrun_o for one cycle, drop the new frame, and leave the held frame untouched.
- REQ-031 dataout_o, parity_err_o and frame_err_o shall not change while valid = 1 and ready = 0.
- REQ-032 Error flags are informational only; a frame with errors shall still be delivered (except break).
- REQ-033 All outputs shall be registered.

Reset
- REQ-034 resetn_i = 0 at posedge clk_i sets: FSM IDLE, counters 0, shift register 0, synchronizer flops 1.
- REQ-035 Same reset clears all outputs: dataout_o = 0, dataout_valid_o = 0, parity_err_o = 0, frame_err_o = 0, overrun_o = 0, break_o = 0.
- REQ-036 Reset mid-frame shall abandon the frame with no output. After release, reception restarts only on a new falling edge seen in IDLE.
- REQ-037 Reset has priority over clk_en_i and dataout_ready_i.

Verification (OVERSAMPLE = 4, clk_en_i every 2nd cycle unless stated)
- REQ-038 8N1, send 0xA5, ready = 1 -> dataout_o = 0xA5, valid for exactly 1 cycle, both error flags 0.
- REQ-039 8E1, send 0x07 with parity bit 0 -> dataout_o = 0x07, parity_err_o = 1. Then send 0x07 with parity 1 -> parity_err_o = 0. Repeat in 8O1 with parity 0 -> parity_err_o = 0.
- REQ-040 8N2, send 0x3C with second stop bit 0 -> dataout_o = 0x3C, frame_err_o = 1. Then hold the line low for 12 bit times -> break_o pulses once, no valid. Release high, send 0x11 -> 0x11 delivered cleanly.
- REQ-041 ready = 0, send 0x01 then 0x02 back-to-back -> valid holds 0x01, overrun_o pulses once, 0x02 lost. With ready = 1 in the delivery cycle of a third frame 0x03 -> 0x03 loaded, no overrun.
- REQ-042 Glitch: rx low for 1 tick only -> no frame, FSM back in IDLE. Assert resetn_i = 0 during bit 4 of a frame -> all outputs 0 next cycle, no delivery. A following clean frame 0x5A decodes correctly.
- REQ-043 DATA_BITS = 5 and 9 builds, send 0x15 / 0x1A5 -> decoded exactly, upper bits of dataout_o correct width.
